// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, with MTHI/MTLO write path.
module mult_div_unit #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  hi_we,
  input  logic                  lo_we,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero,
  output logic [DATA_WIDTH-1:0] HI,
  output logic [DATA_WIDTH-1:0] LO
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(W);

  typedef enum logic [1:0] {StIdle, StCalc, StFinish} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            is_div_q, is_div_d;
  logic            neg_lo_q, neg_lo_d;
  logic            neg_hi_q, neg_hi_d;
  logic            dbz_pend_q, dbz_pend_d;
  logic [W-1:0]    opnd_q, opnd_d;
  logic [W-1:0]    acc_hi_q, acc_hi_d;
  logic [W-1:0]    acc_lo_q, acc_lo_d;
  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    lo_q, lo_d;
  logic            done_q, done_d;
  logic            dbz_q, dbz_d;

  logic            op_signed, a_neg, b_neg;
  logic [W-1:0]    a_mag, b_mag;
  logic [W:0]      mul_sum, rem_sh, rem_diff;
  logic [2*W-1:0]  prod_abs;

  assign op_signed = ~op[0];
  assign a_neg     = op_signed & A[W-1];
  assign b_neg     = op_signed & B[W-1];
  assign a_mag     = a_neg ? -A : A;
  assign b_mag     = b_neg ? -B : B;

  // Multiply: acc_hi accumulates, acc_lo holds the multiplier and collects low product bits.
  assign mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
  assign rem_sh   = {acc_hi_q, acc_lo_q[W-1]};
  assign rem_diff = rem_sh - {1'b0, opnd_q};
  assign prod_abs = {acc_hi_q, acc_lo_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_lo_d   = neg_lo_q;
    neg_hi_d   = neg_hi_q;
    dbz_pend_d = dbz_pend_q;
    opnd_d     = opnd_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    dbz_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          is_div_d   = op[1];
          cnt_d      = '0;
          acc_hi_d   = '0;
          dbz_pend_d = 1'b0;
          neg_lo_d   = a_neg ^ b_neg;
          if (op[1]) begin
            acc_lo_d = a_mag;
            opnd_d   = b_mag;
            neg_hi_d = a_neg;
            if (B == '0) begin
              dbz_pend_d = 1'b1;
              state_d    = StFinish;
            end else begin
              state_d = StCalc;
            end
          end else begin
            acc_lo_d = b_mag;
            opnd_d   = a_mag;
            neg_hi_d = a_neg ^ b_neg;
            state_d  = StCalc;
          end
        end else begin
          if (hi_we) hi_d = WriteData;
          if (lo_we) lo_d = WriteData;
        end
      end
      StCalc: begin
        if (is_div_q) begin
          acc_hi_d = rem_diff[W] ? rem_sh[W-1:0] : rem_diff[W-1:0];
          acc_lo_d = {acc_lo_q[W-2:0], ~rem_diff[W]};
        end else begin
          acc_hi_d = mul_sum[W:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[W-1:1]};
        end
        if (cnt_q == CW'(W - 1)) begin
          cnt_d   = '0;
          state_d = StFinish;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFinish: begin
        done_d     = 1'b1;
        dbz_pend_d = 1'b0;
        state_d    = StIdle;
        if (dbz_pend_q) begin
          dbz_d = 1'b1;
        end else if (is_div_q) begin
          lo_d = neg_lo_q ? -acc_lo_q : acc_lo_q;
          hi_d = neg_hi_q ? -acc_hi_q : acc_hi_q;
        end else begin
          {hi_d, lo_d} = neg_lo_q ? -prod_abs : prod_abs;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      dbz_pend_q <= 1'b0;
      opnd_q     <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_lo_q   <= neg_lo_d;
      neg_hi_q   <= neg_hi_d;
      dbz_pend_q <= dbz_pend_d;
      opnd_q     <= opnd_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign HI          = hi_q;
  assign LO          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed ops push expected HI/LO,
// a negedge monitor pops and compares on every done pulse.
module tb_mult_div_unit;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  A, B;
  logic          hi_we, lo_we;
  logic [W-1:0]  WriteData;
  logic          busy, done, div_by_zero;
  logic [W-1:0]  HI, LO;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [1:0] OpMult = 2'b00, OpMultu = 2'b01, OpDiv = 2'b10, OpDivu = 2'b11;

  mult_div_unit #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .A          (A),
    .B          (B),
    .hi_we      (hi_we),
    .lo_we      (lo_we),
    .WriteData  (WriteData),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .HI         (HI),
    .LO         (LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", {31'b0, done}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result_hi", HI, e.hi);
        check("result_lo", LO, e.lo);
        check("result_dbz", {31'b0, div_by_zero}, {31'b0, e.dbz});
      end
    end else if (div_by_zero) begin
      check("dbz_without_done", {31'b0, div_by_zero}, 32'd0);
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                        input logic exp_dbz, input int exp_busy, input int inject_at,
                        input logic we_with_start);
    int cycles;
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1; op = o; A = a; B = b;
    hi_we = we_with_start; lo_we = we_with_start; WriteData = 32'h0000_0055;
    e.hi = exp_hi; e.lo = exp_lo; e.dbz = exp_dbz;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    A = 32'hDEAD_BEEF; B = 32'h0BAD_F00D;
    cycles = 0;
    while (busy && cycles < 200) begin
      cycles++;
      if (cycles == inject_at) begin
        start = 1'b1; op = OpMultu; A = 32'd7; B = 32'd9;
        hi_we = 1'b1; WriteData = 32'h0000_DEAD;
      end else begin
        start = 1'b0; hi_we = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; hi_we = 1'b0;
    check("busy_cycles", cycles, exp_busy);
    check("done_high", {31'b0, done}, 32'd1);
    @(posedge clk); #1;
    check("done_pulse_ends", {31'b0, done}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; A = '0; B = '0;
    hi_we = 1'b0; lo_we = 1'b0; WriteData = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_dbz", {31'b0, div_by_zero}, 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);

    // MTHI + MTLO in the same cycle write both registers.
    hi_we = 1'b1; lo_we = 1'b1; WriteData = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    check("mthi_mtlo_hi", HI, 32'hA5A5_A5A5);
    check("mthi_mtlo_lo", LO, 32'hA5A5_A5A5);

    run_op(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33, 0, 1'b0);
    run_op(OpMult,  32'hFFFF_FFF9, 32'd6,         32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0, 33, 0, 1'b0);
    run_op(OpMult,  32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'h0000_0000, 32'd12,        1'b0, 33, 0, 1'b0);
    run_op(OpDiv,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, 0, 1'b0);
    run_op(OpDiv,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, 33, 0, 1'b0);
    run_op(OpDiv,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 33, 0, 1'b0);
    run_op(OpDivu,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 33, 0, 1'b0);
    // Divide by zero leaves HI/LO from the DIVU above untouched.
    run_op(OpDiv,   32'd5,         32'd0,         32'd2,         32'd14,        1'b1, 1,  0, 1'b0);
    // Start wins over a same-cycle MTHI/MTLO.
    run_op(OpMultu, 32'd2,         32'd3,         32'd0,         32'd6,         1'b0, 33, 0, 1'b1);
    // Start and MTHI issued mid-operation are ignored.
    run_op(OpMultu, 32'd3,         32'd5,         32'd0,         32'd15,        1'b0, 33, 5, 1'b0);

    // Reset in the middle of a DIVU aborts with no done pulse.
    @(posedge clk); #1;
    start = 1'b1; op = OpDivu; A = 32'd1000; B = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    check("busy_before_abort", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    lo_we = 1'b1; WriteData = 32'h0000_1234;
    @(posedge clk); #1;
    lo_we = 1'b0;
    check("mtlo_lo", LO, 32'h0000_1234);
    check("mtlo_hi", HI, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
